// File: rtl/sid_bus_writer_if.sv
// Request side of the SID register-write queue: a valid/ready handshake carrying one
// voice/address/data register write per transfer.
interface sid_bus_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_voice;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, wr_voice, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_voice, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/sid_bus_writer.sv
// Queues SID register writes in a small FIFO and replays each as a setup / strobe / hold
// sequence on the tt_um_sid ui_in / uio_in pins.
module sid_bus_writer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  sid_bus_writer_if.slave               bus,
  output logic [7:0]                    o_sid_ui,
  output logic [7:0]                    o_sid_uio,
  output logic                          o_busy,
  output logic                          o_wr_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned MAXC = (SETUP_CYC > STROBE_CYC)
                                 ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                 : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_load;
  logic            w_cnt_zero;

  logic [12:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic            w_full, w_empty, w_push, w_pop;
  logic [12:0]     w_head;

  logic            r_wr, r_wr_done;
  logic [4:0]      r_va;
  logic [7:0]      r_data;
  logic            w_rise, w_fall;

  // FIFO
  assign w_full       = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty      = (r_level == '0);
  assign bus.wr_ready = ~i_rst & ~w_full;
  assign w_push       = bus.wr_valid & bus.wr_ready;
  assign w_head       = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.wr_voice, bus.wr_addr, bus.wr_data};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM: state register and per-state down-counter
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next) r_cnt <= w_cnt_load;
      else if (!w_cnt_zero)  r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = '0;
    case (r_state)
      S_IDLE:   if (!w_empty)  w_next = S_SETUP;
      S_SETUP:  if (w_cnt_zero) w_next = S_STROBE;
      S_STROBE: if (w_cnt_zero) w_next = S_HOLD;
      S_HOLD:   if (w_cnt_zero) w_next = w_empty ? S_IDLE : S_SETUP;
      default:  w_next = S_IDLE;
    endcase
    case (w_next)
      S_SETUP:  w_cnt_load = CW'(SETUP_CYC - 1);
      S_STROBE: w_cnt_load = CW'(STROBE_CYC - 1);
      S_HOLD:   w_cnt_load = CW'(HOLD_CYC - 1);
      default:  w_cnt_load = '0;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      S_IDLE:   w_pop  = ~w_empty;
      S_SETUP:  w_rise = w_cnt_zero;
      S_STROBE: w_fall = w_cnt_zero;
      S_HOLD:   w_pop  = w_cnt_zero & ~w_empty;
      default:  ;
    endcase
  end

  // Pin registers: bus fields change only on a pop, which never coincides with wr=1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr      <= 1'b0;
      r_wr_done <= 1'b0;
      r_va      <= '0;
      r_data    <= '0;
    end else begin
      r_wr_done <= w_fall;
      if (w_pop) {r_va, r_data} <= w_head;
      if (w_rise)      r_wr <= 1'b1;
      else if (w_fall) r_wr <= 1'b0;
    end
  end

  assign o_sid_ui     = {r_wr, 2'b00, r_va};
  assign o_sid_uio    = r_data;
  assign o_wr_done    = r_wr_done;
  assign o_fifo_level = r_level;
  assign o_busy       = (r_state != S_IDLE) | ~w_empty;
endmodule

// File: tb/tb_sid_bus_writer.sv
// Directed bench for sid_bus_writer: single writes, init burst with FIFO full/pop, and
// reset during strobe.
module tb_sid_bus_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sid_ui, sid_uio;
  logic       busy, wr_done;
  logic [2:0] level;
  int unsigned vecs = 0;
  int unsigned errs = 0;

  sid_bus_writer_if u_if();

  sid_bus_writer #(
    .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(u_if),
    .o_sid_ui(sid_ui), .o_sid_uio(sid_uio), .o_busy(busy),
    .o_wr_done(wr_done), .o_fifo_level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ui, input logic [7:0] d);
    u_if.wr_voice = ui[4:3];
    u_if.wr_addr  = ui[2:0];
    u_if.wr_data  = d;
  endtask

  // Burst: {voice,addr} as expected on sid_ui[4:0], and data
  logic [7:0] b_ui [9] = '{8'h00, 8'h01, 8'h05, 8'h06, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h04};
  logic [7:0] b_d  [9] = '{8'h1D, 8'h07, 8'h00, 8'hF0, 8'h00, 8'h40, 8'h00, 8'h0F, 8'h21};
  logic [7:0] s_ui [9];
  logic [7:0] s_uio[9];
  int         s_t  [9];

  initial begin
    int  idx, ns;
    logic acc, prev_wr;
    u_if.wr_valid = 1'b0;
    drive(8'h00, 8'h00);

    // Reset state
    #12;
    chk("rst_ready", u_if.wr_ready, 0);
    chk("rst_ui", sid_ui, 8'h00);
    chk("rst_uio", sid_uio, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", wr_done, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_ready", u_if.wr_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single write voice0 addr0 0x1D
    u_if.wr_valid = 1'b1;
    drive(8'h00, 8'h1D);
    tick;
    u_if.wr_valid = 1'b0;
    chk("t1_e0_level", level, 1);
    chk("t1_e0_busy", busy, 1);
    chk("t1_e0_uio", sid_uio, 8'h00);
    tick;
    chk("t1_setup_ui", sid_ui, 8'h00);
    chk("t1_setup_uio", sid_uio, 8'h1D);
    chk("t1_setup_level", level, 0);
    tick;
    chk("t1_strobe1_ui", sid_ui, 8'h80);
    chk("t1_strobe1_done", wr_done, 0);
    tick;
    chk("t1_strobe2_ui", sid_ui, 8'h80);
    tick;
    chk("t1_hold_ui", sid_ui, 8'h00);
    chk("t1_hold_uio", sid_uio, 8'h1D);
    chk("t1_hold_done", wr_done, 1);
    chk("t1_hold_busy", busy, 1);
    tick;
    chk("t1_idle_done", wr_done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_uio", sid_uio, 8'h1D);

    // Voice 3 addr 3 data 0x0F
    u_if.wr_valid = 1'b1;
    drive(8'h1B, 8'h0F);
    tick;
    u_if.wr_valid = 1'b0;
    tick;
    chk("t3_setup_ui", sid_ui, 8'h1B);
    chk("t3_setup_uio", sid_uio, 8'h0F);
    tick;
    chk("t3_strobe1_ui", sid_ui, 8'h9B);
    tick;
    chk("t3_strobe2_ui", sid_ui, 8'h9B);
    tick;
    chk("t3_hold_ui", sid_ui, 8'h1B);
    chk("t3_hold_done", wr_done, 1);
    tick;
    chk("t3_idle_ui", sid_ui, 8'h1B);
    chk("t3_idle_busy", busy, 0);

    // Nine-write init burst, valid held high while entries remain
    idx = 0;
    ns = 0;
    prev_wr = 1'b0;
    u_if.wr_valid = 1'b1;
    drive(b_ui[0], b_d[0]);
    for (int k = 0; k < 40; k++) begin
      acc = u_if.wr_valid && u_if.wr_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 9) drive(b_ui[idx], b_d[idx]);
        else u_if.wr_valid = 1'b0;
      end
      if (k == 4) begin
        chk("burst_level_full", level, 4);
        chk("burst_ready_full", u_if.wr_ready, 0);
      end
      if (k == 5) begin
        chk("full_pop_level", level, 3);
        chk("full_pop_refused", 16'(idx), 5);
      end
      if (sid_ui[7] && !prev_wr && ns < 9) begin
        s_ui[ns]  = sid_ui;
        s_uio[ns] = sid_uio;
        s_t[ns]   = k;
        ns++;
      end
      prev_wr = sid_ui[7];
    end
    chk("burst_strobes", 16'(ns), 9);
    chk("burst_first_rise", 16'(s_t[0]), 2);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("burst_ui[%0d]", i), s_ui[i], b_ui[i] | 8'h80);
      chk($sformatf("burst_uio[%0d]", i), s_uio[i], b_d[i]);
      if (i > 0) chk($sformatf("burst_gap[%0d]", i), 16'(s_t[i] - s_t[i-1]), 4);
    end
    chk("burst_end_busy", busy, 0);
    chk("burst_end_level", level, 0);

    // Reset asserted during strobe
    u_if.wr_valid = 1'b1;
    drive(8'h0A, 8'h55);
    for (int k = 0; k < 3; k++) tick;
    u_if.wr_valid = 1'b0;
    for (int k = 0; k < 10 && !sid_ui[7]; k++) tick;
    chk("t4_strobe_seen", sid_ui[7], 1);
    chk("t4_level_before", level, 2);
    rst = 1'b1;
    #1;
    chk("t4_rst_ui", sid_ui, 8'h00);
    chk("t4_rst_uio", sid_uio, 8'h00);
    chk("t4_rst_level", level, 0);
    chk("t4_rst_ready", u_if.wr_ready, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("t4_rel_busy", busy, 0);
    chk("t4_rel_ready", u_if.wr_ready, 1);
    for (int k = 0; k < 6; k++) tick;
    chk("t4_quiet_ui", sid_ui, 8'h00);
    chk("t4_quiet_done", wr_done, 0);
    chk("t4_quiet_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
